uart_msg_tx: RTL and testbench

//  Transmit side of the lock console UART link: command decoding arrives on rx, and this block sends status text back on tx.
//  It takes a one-cycle message request from the lock controller, latches a message ID and six BCD countdown digits, and serialises a fixed ASCII string as 8N1.
//  It sits beside the command receiver, in the top level, clocked by clk.

---
 rtl/lock_pkg.sv | 32 +++
 rtl/uart_byte_tx.sv | 89 ++++++++
 rtl/uart_msg_tx.sv | 146 ++++++++++++++
 tb/tb_uart_msg_tx.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/lock_pkg.sv
// Shared constants and helpers for the lock console: message IDs, ASCII codes,
// BCD-to-ASCII conversion and message lengths.
package lock_pkg;

    localparam logic [1:0] MSG_OK   = 2'd0;
    localparam logic [1:0] MSG_ERR  = 2'd1;
    localparam logic [1:0] MSG_TIME = 2'd2;
    localparam logic [1:0] MSG_LOCK = 2'd3;

    localparam logic [7:0] ASCII_CR    = 8'h0D;
    localparam logic [7:0] ASCII_LF    = 8'h0A;
    localparam logic [7:0] ASCII_COLON = 8'h3A;
    localparam logic [7:0] ASCII_QMARK = 8'h3F;
    localparam logic [7:0] ASCII_ZERO  = 8'h30;

    // Non-decimal nibbles print as '?' so a corrupt countdown is visible on the console.
    function automatic logic [7:0] bcd2ascii(input logic [3:0] d);
        return (d > 4'd9) ? ASCII_QMARK : (ASCII_ZERO + {4'h0, d});
    endfunction

    function automatic logic [3:0] msg_len(input logic [1:0] id);
        logic [3:0] len;
        case (id)
            MSG_OK:   len = 4'd4;
            MSG_ERR:  len = 4'd5;
            MSG_LOCK: len = 4'd6;
            default:  len = 4'd10;
        endcase
        return len;
    endfunction

endpackage

// File: rtl/uart_byte_tx.sv
// 8N1 byte serialiser. A byte offered in the last cycle of a stop bit starts
// its start bit on the very next cycle, so a stream of bytes has no idle gap.
module uart_byte_tx #(
    parameter int DIV = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       byte_valid,
    input  logic [7:0] byte_in,
    output logic       byte_ready,
    output logic       tx
);
    import lock_pkg::*;

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] BAUD_LAST = CW'(DIV - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    logic [1:0]    state_reg;
    logic [CW-1:0] baud_cnt_reg;
    logic [2:0]    bit_cnt_reg;
    logic [7:0]    shift_reg;
    logic          tx_reg;
    logic          bit_end;

    assign bit_end    = (baud_cnt_reg == BAUD_LAST);
    assign byte_ready = (state_reg == S_IDLE) || ((state_reg == S_STOP) && bit_end);
    assign tx         = tx_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= S_IDLE;
            baud_cnt_reg <= '0;
            bit_cnt_reg  <= 3'd0;
            shift_reg    <= 8'h00;
            tx_reg       <= 1'b1;
        end else begin
            if (state_reg != S_IDLE)
                baud_cnt_reg <= bit_end ? '0 : baud_cnt_reg + CW'(1);

            case (state_reg)
                S_IDLE: begin
                    if (byte_valid) begin
                        state_reg    <= S_START;
                        shift_reg    <= byte_in;
                        baud_cnt_reg <= '0;
                        tx_reg       <= 1'b0;
                    end
                end
                S_START: begin
                    if (bit_end) begin
                        state_reg   <= S_DATA;
                        bit_cnt_reg <= 3'd0;
                        tx_reg      <= shift_reg[0];
                        shift_reg   <= {1'b0, shift_reg[7:1]};
                    end
                end
                S_DATA: begin
                    if (bit_end) begin
                        if (bit_cnt_reg == 3'd7) begin
                            state_reg <= S_STOP;
                            tx_reg    <= 1'b1;
                        end else begin
                            bit_cnt_reg <= bit_cnt_reg + 3'd1;
                            tx_reg      <= shift_reg[0];
                            shift_reg   <= {1'b0, shift_reg[7:1]};
                        end
                    end
                end
                default: begin
                    if (bit_end) begin
                        if (byte_valid) begin
                            state_reg <= S_START;
                            shift_reg <= byte_in;
                            tx_reg    <= 1'b0;
                        end else begin
                            state_reg <= S_IDLE;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: rtl/uart_msg_tx.sv
// Lock console status transmitter: latches a message request and streams the
// selected ASCII string through the byte serialiser without inter-byte gaps.
module uart_msg_tx #(
    parameter int CLK_FREQ = 100_000_000,
    parameter int BAUD     = 115200
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        msg_req,
    input  logic [1:0]  msg_id,
    input  logic [23:0] bcd_in,
    output logic        busy,
    output logic        done,
    output logic        msg_drop,
    output logic        tx
);
    import lock_pkg::*;

    localparam int DIV = CLK_FREQ / BAUD;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_SEND = 1'b1;

    logic [0:0]  state_reg;
    logic [1:0]  id_reg;
    logic [23:0] digits_reg;
    logic [3:0]  idx_reg;
    logic        done_reg;
    logic        drop_reg;

    logic        accept;
    logic        last_byte;
    logic        advance;
    logic        finish;
    logic        byte_valid;
    logic        byte_ready;
    logic [7:0]  byte_sel;
    logic [1:0]  sel_id;
    logic [23:0] sel_digits;
    logic [3:0]  sel_idx;
    logic [7:0]  digit_ascii [6];

    assign busy     = (state_reg == ST_SEND);
    assign done     = done_reg;
    assign msg_drop = drop_reg;

    assign accept     = msg_req && !busy;
    assign last_byte  = (idx_reg == (msg_len(id_reg) - 4'd1));
    assign advance    = busy && byte_ready && !last_byte;
    assign finish     = busy && byte_ready && last_byte;
    assign byte_valid = accept || advance;

    // Byte 0 goes out in the accept cycle, before the latches hold the request.
    assign sel_id     = busy ? id_reg : msg_id;
    assign sel_digits = busy ? digits_reg : bcd_in;
    assign sel_idx    = busy ? (idx_reg + 4'd1) : 4'd0;

    generate
        for (genvar gi = 0; gi < 6; gi++) begin : g_digit
            assign digit_ascii[gi] = bcd2ascii(sel_digits[4*gi +: 4]);
        end
    endgenerate

    always_comb begin
        byte_sel = ASCII_LF;
        case (sel_id)
            MSG_OK: begin
                case (sel_idx)
                    4'd0:    byte_sel = "O";
                    4'd1:    byte_sel = "K";
                    4'd2:    byte_sel = ASCII_CR;
                    default: byte_sel = ASCII_LF;
                endcase
            end
            MSG_ERR: begin
                case (sel_idx)
                    4'd0:    byte_sel = "E";
                    4'd1:    byte_sel = "R";
                    4'd2:    byte_sel = "R";
                    4'd3:    byte_sel = ASCII_CR;
                    default: byte_sel = ASCII_LF;
                endcase
            end
            MSG_LOCK: begin
                case (sel_idx)
                    4'd0:    byte_sel = "L";
                    4'd1:    byte_sel = "O";
                    4'd2:    byte_sel = "C";
                    4'd3:    byte_sel = "K";
                    4'd4:    byte_sel = ASCII_CR;
                    default: byte_sel = ASCII_LF;
                endcase
            end
            default: begin
                case (sel_idx)
                    4'd0:    byte_sel = digit_ascii[5];
                    4'd1:    byte_sel = digit_ascii[4];
                    4'd2:    byte_sel = ASCII_COLON;
                    4'd3:    byte_sel = digit_ascii[3];
                    4'd4:    byte_sel = digit_ascii[2];
                    4'd5:    byte_sel = ASCII_COLON;
                    4'd6:    byte_sel = digit_ascii[1];
                    4'd7:    byte_sel = digit_ascii[0];
                    4'd8:    byte_sel = ASCII_CR;
                    default: byte_sel = ASCII_LF;
                endcase
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= ST_IDLE;
            id_reg     <= 2'd0;
            digits_reg <= 24'h0;
            idx_reg    <= 4'd0;
            done_reg   <= 1'b0;
            drop_reg   <= 1'b0;
        end else begin
            done_reg <= finish;
            drop_reg <= msg_req && busy;
            if (accept) begin
                state_reg  <= ST_SEND;
                id_reg     <= msg_id;
                digits_reg <= bcd_in;
                idx_reg    <= 4'd0;
            end else if (advance) begin
                idx_reg <= idx_reg + 4'd1;
            end else if (finish) begin
                state_reg <= ST_IDLE;
            end
        end
    end

    uart_byte_tx #(
        .DIV (DIV)
    ) u_byte_tx (
        .clk        (clk),
        .rst_n      (rst_n),
        .byte_valid (byte_valid),
        .byte_in    (byte_sel),
        .byte_ready (byte_ready),
        .tx         (tx)
    );

endmodule

// File: tb/tb_uart_msg_tx.sv
// Directed bench for uart_msg_tx at DIV=16: a cycle-exact UART receiver checks
// every bit's hold time and frame spacing; message results are table-driven.
module tb_uart_msg_tx;

    localparam int DIV   = 16;
    localparam int FRAME = 10 * DIV;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        msg_req = 1'b0;
    logic [1:0]  msg_id = 2'd0;
    logic [23:0] bcd_in = 24'h0;
    logic        busy, done, msg_drop, tx;

    uart_msg_tx #(
        .CLK_FREQ (1600),
        .BAUD     (100)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .msg_req  (msg_req),
        .msg_id   (msg_id),
        .bcd_in   (bcd_in),
        .busy     (busy),
        .done     (done),
        .msg_drop (msg_drop),
        .tx       (tx)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Cycle-exact receiver and event counters, sampled on the falling edge.
    logic [7:0] rx_q[$];
    int         rx_start_q[$];
    int         done_cnt = 0;
    int         drop_cnt = 0;
    int         tx_low_cnt = 0;

    initial begin
        bit         rx_act;
        bit         hold_ok;
        int         pos;
        logic       cur_bit;
        logic [7:0] sh;
        rx_act = 0; hold_ok = 1; pos = 0; cur_bit = 1'b1; sh = 8'h00;
        forever begin
            @(negedge clk);
            if (done === 1'b1) done_cnt++;
            if (msg_drop === 1'b1) drop_cnt++;
            if (tx !== 1'b1) tx_low_cnt++;
            if (!rst_n) begin
                rx_act = 0;
            end else if (!rx_act) begin
                if (tx === 1'b0) begin
                    rx_act = 1; pos = 0; cur_bit = 1'b0; hold_ok = 1;
                    rx_start_q.push_back(cyc);
                end
            end else begin
                pos++;
                if (pos % DIV == 0) begin
                    cur_bit = tx;
                    if (pos / DIV >= 1 && pos / DIV <= 8) sh[pos/DIV - 1] = tx;
                end else if (tx !== cur_bit) begin
                    hold_ok = 0;
                end
                if (pos == FRAME - 1) begin
                    rx_act = 0;
                    chk("bit_hold", 32'(hold_ok), 32'd1);
                    chk("stop_bit", 32'(cur_bit), 32'd1);
                    rx_q.push_back(sh);
                    $display("rx byte %02h at cycle %0d", sh, cyc);
                end
            end
        end
    end

    task automatic start_msg(input logic [1:0] id, input logic [23:0] bcd, output int t0);
        rx_q.delete(); rx_start_q.delete();
        done_cnt = 0; drop_cnt = 0;
        @(posedge clk); #1;
        msg_req = 1'b1; msg_id = id; bcd_in = bcd;
        @(posedge clk); #1;
        msg_req = 1'b0; msg_id = ~id; bcd_in = 24'hFFFFFF;
        t0 = cyc;
        chk("start_tx_low", 32'(tx), 32'd0);
        chk("start_busy", 32'(busy), 32'd1);
    endtask

    task automatic wait_done(input int t0, output int latency, output int busy_n);
        bit got;
        got = 0; busy_n = 0; latency = -1;
        for (int i = 0; i < 3000 && !got; i++) begin
            if (busy) busy_n++;
            if (done) got = 1;
            else begin
                @(posedge clk); #1;
            end
        end
        chk("done_timeout", 32'(got), 32'd1);
        if (got) latency = cyc - t0;
    endtask

    task automatic check_rx(input string name, input int n, input logic [79:0] str, input int t0);
        chk({name, "_nbytes"}, 32'(rx_q.size()), 32'(n));
        for (int k = 0; k < n && k < rx_q.size(); k++) begin
            chk($sformatf("%s_byte%0d", name, k), 32'(rx_q[k]), 32'(str[8*(n-1-k) +: 8]));
            chk($sformatf("%s_gap%0d", name, k), 32'(rx_start_q[k]), 32'(t0 + FRAME*k));
        end
        $display("msg %s: %0d bytes received", name, rx_q.size());
    endtask

    typedef struct {
        logic [1:0]  id;
        logic [23:0] bcd;
        int          n;
        int          cycles;
        logic [79:0] str;
    } vec_t;

    vec_t vecs[5];

    initial begin
        int t0, lat, busy_n, t1;

        vecs[0] = '{2'd0, 24'h000000,  4,  640, 80'("OK\r\n")};
        vecs[1] = '{2'd1, 24'h999999,  5,  800, 80'("ERR\r\n")};
        vecs[2] = '{2'd3, 24'h000000,  6,  960, 80'("LOCK\r\n")};
        vecs[3] = '{2'd2, 24'h123456, 10, 1600, 80'("12:34:56\r\n")};
        vecs[4] = '{2'd2, 24'h0A0000, 10, 1600, 80'("0?:00:00\r\n")};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_tx", 32'(tx), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_drop", 32'(msg_drop), 32'd0);
        rst_n = 1'b1;
        repeat (5) @(posedge clk);

        // Table-driven messages
        for (int v = 0; v < 5; v++) begin
            start_msg(vecs[v].id, vecs[v].bcd, t0);
            wait_done(t0, lat, busy_n);
            chk($sformatf("v%0d_latency", v), 32'(lat), 32'(vecs[v].cycles));
            chk($sformatf("v%0d_busy_cycles", v), 32'(busy_n), 32'(vecs[v].cycles));
            chk($sformatf("v%0d_done_busy", v), 32'(busy), 32'd0);
            chk($sformatf("v%0d_done_tx", v), 32'(tx), 32'd1);
            @(posedge clk); #1;
            chk($sformatf("v%0d_done_pulse", v), 32'(done), 32'd0);
            repeat (3) @(posedge clk);
            #1;
            chk($sformatf("v%0d_done_cnt", v), 32'(done_cnt), 32'd1);
            check_rx($sformatf("v%0d", v), vecs[v].n, vecs[v].str, t0);
        end

        // Drop: second request 100 cycles into ERR
        start_msg(2'd1, 24'h0, t0);
        repeat (99) @(posedge clk);
        #1;
        msg_req = 1'b1; msg_id = 2'd0;
        @(posedge clk); #1;
        msg_req = 1'b0;
        chk("drop_pulse", 32'(msg_drop), 32'd1);
        @(posedge clk); #1;
        chk("drop_one_cycle", 32'(msg_drop), 32'd0);
        wait_done(t0, lat, busy_n);
        chk("drop_latency", 32'(lat), 32'd800);
        repeat (3) @(posedge clk);
        #1;
        chk("drop_done_cnt", 32'(done_cnt), 32'd1);
        chk("drop_cnt", 32'(drop_cnt), 32'd1);
        check_rx("drop_err", 5, 80'("ERR\r\n"), t0);

        // Back-to-back: LOCK requested in the done cycle of OK
        start_msg(2'd0, 24'h0, t0);
        wait_done(t0, lat, busy_n);
        chk("b2b_ok_latency", 32'(lat), 32'd640);
        chk("b2b_idle_tx", 32'(tx), 32'd1);
        check_rx("b2b_ok", 4, 80'("OK\r\n"), t0);
        rx_q.delete(); rx_start_q.delete(); drop_cnt = 0; done_cnt = 0;
        msg_req = 1'b1; msg_id = 2'd3;
        @(posedge clk); #1;
        msg_req = 1'b0; msg_id = 2'd0;
        t1 = cyc;
        chk("b2b_lock_tx_low", 32'(tx), 32'd0);
        chk("b2b_lock_busy", 32'(busy), 32'd1);
        wait_done(t1, lat, busy_n);
        chk("b2b_lock_latency", 32'(lat), 32'd960);
        repeat (3) @(posedge clk);
        #1;
        chk("b2b_no_drop", 32'(drop_cnt), 32'd0);
        check_rx("b2b_lock", 6, 80'("LOCK\r\n"), t1);

        // Asynchronous reset in the middle of a TIME message
        start_msg(2'd2, 24'h123456, t0);
        repeat (300) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_tx", 32'(tx), 32'd1);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_done", 32'(done), 32'd0);
        rx_q.delete(); tx_low_cnt = 0; done_cnt = 0;
        repeat (3) @(posedge clk);
        #3;
        rst_n = 1'b1;
        repeat (200) @(posedge clk);
        #1;
        chk("arst_tx_idle", 32'(tx_low_cnt), 32'd0);
        chk("arst_no_done", 32'(done_cnt), 32'd0);
        chk("arst_no_bytes", 32'(rx_q.size()), 32'd0);
        chk("arst_busy_after", 32'(busy), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
